// File: rtl/packet_writer.sv
// packet_writer: ingress byte-stream to FIFO-slot writer.
// Frames source/dest/size/payload/crc, commits the slot on a good checksum.
module packet_writer #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int MAX_SIZE  = 12
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [UWIDTH-1:0]    in_data,
    output logic                 in_ready,
    input  logic                 wfull,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 winc,
    output logic                 pkt_sent,
    output logic                 crc_err,
    output logic                 len_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEST = 3'd1,
        SIZE = 3'd2,
        DATA = 3'd3,
        CRC  = 3'd4,
        GAP  = 3'd5,
        DROP = 3'd6
    } state_t;

    localparam logic [UWIDTH-1:0] MAX_V = UWIDTH'(MAX_SIZE);

    state_t                 state_q, state_d;
    logic [7:0]             size_q, size_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [UWIDTH-1:0]      csum_q, csum_d;
    logic [PTR_IN_SZ-1:0]   waddr_q, waddr_d;
    logic [UWIDTH-1:0]      wdata_q, wdata_d;
    logic                   winc_q, winc_d;
    logic                   sent_q, sent_d;
    logic                   crc_err_q, crc_err_d;
    logic                   len_err_q, len_err_d;
    logic                   xfer;

    // Ready depends only on state; wfull can only hold off a new packet.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = !wfull;
            GAP:     in_ready = 1'b0;
            default: in_ready = 1'b1;
        endcase
        in_ready = in_ready & rst;
    end

    assign xfer = in_valid & in_ready;

    // Framing: next state, slot address/data, checksum and event pulses.
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        winc_d    = 1'b0;
        sent_d    = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    waddr_d = '0;
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = DEST;
                end
            end
            DEST: begin
                if (xfer) begin
                    waddr_d = PTR_IN_SZ'(1);
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    waddr_d = PTR_IN_SZ'(2);
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    size_d  = 8'(in_data);
                    if (in_data > MAX_V) begin
                        // count holds remaining-1 so size=255 fits in 8 bits
                        len_err_d = 1'b1;
                        cnt_d     = 8'(in_data);
                        state_d   = DROP;
                    end else if (in_data == '0) begin
                        state_d = CRC;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    waddr_d = PTR_IN_SZ'(cnt_q + 8'd3);
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    cnt_d   = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == size_q) begin
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                if (xfer) begin
                    waddr_d = PTR_IN_SZ'(size_q + 8'd3);
                    wdata_d = in_data;
                    if (in_data == csum_q) begin
                        winc_d = 1'b1;
                        sent_d = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                csum_d  = '0;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            DROP: begin
                if (xfer) begin
                    if (cnt_q == 8'd0) begin
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            size_q    <= 8'd0;
            cnt_q     <= 8'd0;
            csum_q    <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            winc_q    <= 1'b0;
            sent_q    <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            winc_q    <= winc_d;
            sent_q    <= sent_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
        end
    end

    assign waddr_in = waddr_q;
    assign wdata    = wdata_q;
    assign winc     = winc_q;
    assign pkt_sent = sent_q;
    assign crc_err  = crc_err_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_packet_writer.sv
// tb_packet_writer: directed packets against a byte-position model.
// Outputs are compared to the model on every falling edge.
module tb_packet_writer;

    localparam int MAXS = 12;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       wfull = 1'b0;
    logic [3:0] waddr_in;
    logic [7:0] wdata;
    logic       winc;
    logic       pkt_sent;
    logic       crc_err;
    logic       len_err;

    packet_writer #(
        .UWIDTH(8),
        .PTR_IN_SZ(4),
        .MAX_SIZE(MAXS)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .wfull(wfull),
        .waddr_in(waddr_in),
        .wdata(wdata),
        .winc(winc),
        .pkt_sent(pkt_sent),
        .crc_err(crc_err),
        .len_err(len_err)
    );

    always #5 clk1 = ~clk1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: position of the next byte within the packet.
    int         m_pos = 0;
    int         m_size = 0;
    int         m_rem = 0;
    bit         m_drop = 0;
    bit         m_gap = 0;
    logic [7:0] m_sum = 0;
    int         m_addr = 0;
    logic [7:0] m_data = 0;
    bit         m_winc = 0;
    bit         m_cerr = 0;
    bit         m_lerr = 0;

    function automatic bit m_ready();
        if (!rst) return 1'b0;
        if (m_gap) return 1'b0;
        if (m_drop) return 1'b1;
        if (m_pos == 0) return !wfull;
        return 1'b1;
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk1 or negedge rst);
            if (!rst) begin
                m_pos = 0; m_size = 0; m_rem = 0; m_drop = 0; m_gap = 0;
                m_sum = 0; m_addr = 0; m_data = 0;
                m_winc = 0; m_cerr = 0; m_lerr = 0;
            end else begin
                acc = in_valid && m_ready();
                m_winc = 0; m_cerr = 0; m_lerr = 0;
                if (m_gap) begin
                    m_gap = 0;
                    m_sum = 0;
                end else if (acc && m_drop) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_drop = 0;
                        m_gap = 1;
                    end
                end else if (acc) begin
                    m_addr = m_pos;
                    m_data = in_data;
                    if (m_pos >= 3 && m_pos == m_size + 3) begin
                        if (in_data == m_sum) m_winc = 1;
                        else m_cerr = 1;
                        m_gap = 1;
                        m_pos = 0;
                    end else begin
                        m_sum = m_sum ^ in_data;
                        if (m_pos == 2 && int'(in_data) > MAXS) begin
                            m_lerr = 1;
                            m_drop = 1;
                            m_rem = int'(in_data) + 1;
                            m_pos = 0;
                        end else begin
                            if (m_pos == 2) m_size = int'(in_data);
                            m_pos++;
                        end
                    end
                end
            end
        end
    end

    // Event counters and last committed slot byte, for literal checks.
    int         c_winc = 0;
    int         c_cerr = 0;
    int         c_lerr = 0;
    int         l_addr = 0;
    int         l_data = 0;

    initial begin
        forever begin
            @(negedge clk1);
            chk("in_ready", int'(in_ready), int'(m_ready()));
            chk("waddr_in", int'(waddr_in), m_addr % 16);
            chk("wdata", int'(wdata), int'(m_data));
            chk("winc", int'(winc), int'(m_winc));
            chk("pkt_sent", int'(pkt_sent), int'(m_winc));
            chk("crc_err", int'(crc_err), int'(m_cerr));
            chk("len_err", int'(len_err), int'(m_lerr));
            if (winc) begin
                c_winc++;
                l_addr = int'(waddr_in);
                l_data = int'(wdata);
            end
            if (crc_err) c_cerr++;
            if (len_err) c_lerr++;
        end
    end

    logic [7:0] pkt[$];
    int         cyc;

    task automatic send_byte(input logic [7:0] b);
        bit acc = 0;
        in_valid = 1'b1;
        in_data = b;
        for (int n = 0; n < 50 && !acc; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk1);
            @(negedge clk1);
            #2;
            cyc++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_pkt();
        cyc = 0;
        foreach (pkt[i]) send_byte(pkt[i]);
        in_valid = 1'b0;
    endtask

    task automatic clr();
        c_winc = 0; c_cerr = 0; c_lerr = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk1);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        idle(2);
        chk("rst_waddr", int'(waddr_in), 0);
        chk("rst_ready", int'(in_ready), 0);
        rst = 1'b1;
        idle(2);

        // good size-3 packet
        clr();
        pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
        send_pkt();
        chk("t1_cycles", cyc, 7);
        chk("t1_gap_ready", int'(in_ready), 0);
        chk("t1_winc_cnt", c_winc, 1);
        chk("t1_addr", l_addr, 6);
        chk("t1_data", l_data, 170);
        idle(2);

        // bad checksum then size-0 packet back-to-back
        clr();
        pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        send_pkt();
        chk("t2_bad_winc", c_winc, 0);
        chk("t2_bad_addr", int'(waddr_in), 6);
        pkt = '{8'd100, 8'd10, 8'd0, 8'd110};
        send_pkt();
        chk("t2_winc_cnt", c_winc, 1);
        chk("t2_cerr_cnt", c_cerr, 1);
        chk("t2_addr", l_addr, 3);
        chk("t2_data", l_data, 110);
        idle(1);

        // oversize packet dropped
        clr();
        pkt = '{8'd1, 8'd2, 8'd13};
        repeat (14) pkt.push_back(8'h55);
        send_pkt();
        chk("t3_lerr_cnt", c_lerr, 1);
        chk("t3_winc_cnt", c_winc, 0);
        chk("t3_addr", int'(waddr_in), 2);
        chk("t3_data", int'(wdata), 13);
        pkt = '{8'd5, 8'd6, 8'd1, 8'd7, 8'd5};
        send_pkt();
        chk("t3_next_winc", c_winc, 1);
        chk("t3_next_addr", l_addr, 4);
        chk("t3_next_data", l_data, 5);
        idle(1);

        // max-length payload
        clr();
        pkt = '{8'd1, 8'd2, 8'd12};
        for (int k = 1; k <= 12; k++) pkt.push_back(8'(k));
        pkt.push_back(8'd3);
        send_pkt();
        chk("t4_winc_cnt", c_winc, 1);
        chk("t4_addr", l_addr, 15);
        chk("t4_data", l_data, 3);
        idle(1);

        // wfull blocks only the packet start
        clr();
        wfull = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd9;
        repeat (3) begin
            @(negedge clk1);
            #2;
        end
        chk("t5_full_ready", int'(in_ready), 0);
        chk("t5_full_addr", int'(waddr_in), 15);
        wfull = 1'b0;
        cyc = 0;
        send_byte(8'd9);
        wfull = 1'b1;
        pkt = '{8'd8, 8'd2, 8'd4, 8'd4, 8'd3};
        send_pkt();
        chk("t5_winc_cnt", c_winc, 1);
        chk("t5_addr", l_addr, 5);
        chk("t5_data", l_data, 3);
        wfull = 1'b0;
        idle(1);

        // reset mid-packet
        clr();
        pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1};
        send_pkt();
        rst = 1'b0;
        idle(1);
        chk("t6_rst_addr", int'(waddr_in), 0);
        chk("t6_rst_data", int'(wdata), 0);
        chk("t6_rst_ready", int'(in_ready), 0);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_winc", c_winc, 0);
        pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
        send_pkt();
        chk("t6_winc_cnt", c_winc, 1);
        chk("t6_addr", l_addr, 6);
        chk("t6_data", l_data, 170);
        idle(1);

        // size=255 drop consumes 256 trailing bytes
        clr();
        pkt = '{8'd1, 8'd2, 8'd255};
        repeat (256) pkt.push_back(8'hA5);
        send_pkt();
        chk("t7_lerr_cnt", c_lerr, 1);
        chk("t7_winc_cnt", c_winc, 0);
        chk("t7_cycles", cyc, 259);
        pkt = '{8'd100, 8'd10, 8'd0, 8'd110};
        send_pkt();
        chk("t7_next_winc", c_winc, 1);
        chk("t7_next_addr", l_addr, 3);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
